// File: rtl/led_mode_ctrl.sv
// LED sequencer control: button debounce, mode FSM and
// registered datapath configuration outputs.
module led_mode_ctrl #(
  parameter int N_BTN     = 4,
  parameter int N_ILEDS   = 4,
  parameter int DB_CYCLES = 1000000,
  parameter int DB_WIDTH  = 20
) (
  input  logic               clock,
  input  logic               i_ck_reset,
  input  logic [N_BTN-1:0]   i_btn,
  output logic               o_mux_sel,
  output logic               o_shift_dir,
  output logic [2:0]         o_color,
  output logic               o_run,
  output logic               o_restart,
  output logic [N_ILEDS-1:0] o_ind
);

  typedef enum logic [1:0] {
    S_SHIFT = 2'd0,
    S_FLASH = 2'd1,
    S_PAUSE = 2'd2
  } state_t;

  localparam logic [DB_WIDTH-1:0] CNT_MAX =
    DB_WIDTH'(DB_CYCLES - 1);

  logic [3:0] w_btn;
  logic [3:0] w_db;
  logic [3:0] w_evt;

  assign w_btn = i_btn[3:0];

  for (genvar g = 0; g < 4; g++) begin : g_db
    logic                r_sync1;
    logic                r_sync2;
    logic                r_db;
    logic                r_db_q;
    logic                r_evt;
    logic [DB_WIDTH-1:0] r_cnt;

    // Synchronise, debounce and detect the rising edge of db
    always_ff @(posedge clock or negedge i_ck_reset) begin
      if (!i_ck_reset) begin
        r_sync1 <= 1'b0;
        r_sync2 <= 1'b0;
        r_db    <= 1'b0;
        r_db_q  <= 1'b0;
        r_evt   <= 1'b0;
        r_cnt   <= '0;
      end else begin
        r_sync1 <= w_btn[g];
        r_sync2 <= r_sync1;
        r_db_q  <= r_db;
        r_evt   <= r_db & ~r_db_q;
        if (r_sync2 == r_db) begin
          r_cnt <= '0;
        end else if (r_cnt == CNT_MAX) begin
          r_cnt <= '0;
          r_db  <= r_sync2;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end
    end

    assign w_db[g]  = r_db;
    assign w_evt[g] = r_evt;
  end

  state_t     r_state;
  state_t     w_state_n;
  logic       r_saved;
  logic       w_saved_n;
  logic       w_eff_flash;
  logic       w_mux_n;
  logic       w_dir_n;
  logic [2:0] w_color_n;
  logic       w_run_n;
  logic [3:0] w_ind_n;

  logic       r_mux_sel;
  logic       r_dir;
  logic [2:0] r_color;
  logic       r_run;
  logic       r_restart;
  logic [N_ILEDS-1:0] r_ind;

  // State and resume-mode registers
  always_ff @(posedge clock or negedge i_ck_reset) begin
    if (!i_ck_reset) begin
      r_state <= S_SHIFT;
      r_saved <= 1'b0;
    end else begin
      r_state <= w_state_n;
      r_saved <= w_saved_n;
    end
  end

  // Next state from the pre-event state and all events
  always_comb begin
    w_state_n = r_state;
    w_saved_n = r_saved;
    unique case (r_state)
      S_SHIFT: begin
        if (w_evt[3]) begin
          w_state_n = S_PAUSE;
          w_saved_n = w_evt[0];
        end else if (w_evt[0]) begin
          w_state_n = S_FLASH;
        end
      end
      S_FLASH: begin
        if (w_evt[3]) begin
          w_state_n = S_PAUSE;
          w_saved_n = ~w_evt[0];
        end else if (w_evt[0]) begin
          w_state_n = S_SHIFT;
        end
      end
      default: begin
        if (w_evt[0]) begin
          w_saved_n = ~r_saved;
        end
        if (w_evt[3]) begin
          w_state_n = w_saved_n ? S_FLASH : S_SHIFT;
        end
      end
    endcase
  end

  // Next output values derived from the next state
  always_comb begin
    w_eff_flash = (r_state == S_PAUSE) ? r_saved
                : (r_state == S_FLASH);
    w_mux_n = (w_state_n == S_PAUSE) ? w_saved_n
            : (w_state_n == S_FLASH);
    w_run_n = (w_state_n != S_PAUSE);
    w_dir_n = r_dir;
    if (w_evt[1] && !w_eff_flash && !w_evt[0]) begin
      w_dir_n = ~r_dir;
    end
    w_color_n = r_color;
    if (w_evt[2]) begin
      w_color_n = {r_color[1:0], r_color[2]};
    end
    w_ind_n = {|w_db, ~w_run_n, w_dir_n, w_mux_n};
  end

  // Registered outputs
  always_ff @(posedge clock or negedge i_ck_reset) begin
    if (!i_ck_reset) begin
      r_mux_sel <= 1'b0;
      r_dir     <= 1'b0;
      r_color   <= 3'b001;
      r_run     <= 1'b1;
      r_restart <= 1'b0;
      r_ind     <= '0;
    end else begin
      r_mux_sel <= w_mux_n;
      r_dir     <= w_dir_n;
      r_color   <= w_color_n;
      r_run     <= w_run_n;
      r_restart <= w_evt[0];
      r_ind     <= N_ILEDS'(w_ind_n);
    end
  end

  assign o_mux_sel   = r_mux_sel;
  assign o_shift_dir = r_dir;
  assign o_color     = r_color;
  assign o_run       = r_run;
  assign o_restart   = r_restart;
  assign o_ind       = r_ind;

endmodule

// File: tb/tb_led_mode_ctrl.sv
// Directed bench for led_mode_ctrl with a short
// debounce window.
module tb_led_mode_ctrl;

  localparam int DBC = 4;
  localparam logic [9:0] RST = 10'b0_0_001_1_0000;

  logic       clock = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] btn   = 4'b0000;
  logic       o_mux_sel;
  logic       o_shift_dir;
  logic [2:0] o_color;
  logic       o_run;
  logic       o_restart;
  logic [3:0] o_ind;

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    logic [3:0] btn;
    logic [9:0] exp;
  } vec_t;

  vec_t tbl[26];

  led_mode_ctrl #(
    .N_BTN(4),
    .N_ILEDS(4),
    .DB_CYCLES(DBC),
    .DB_WIDTH(3)
  ) dut (
    .clock(clock),
    .i_ck_reset(rst_n),
    .i_btn(btn),
    .o_mux_sel(o_mux_sel),
    .o_shift_dir(o_shift_dir),
    .o_color(o_color),
    .o_run(o_run),
    .o_restart(o_restart),
    .o_ind(o_ind)
  );

  always #5 clock = ~clock;

  function automatic logic [9:0] outs();
    return {o_mux_sel, o_shift_dir, o_color,
            o_run, o_ind};
  endfunction

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clock);
  endtask

  task automatic press(input logic [3:0] b);
    @(negedge clock);
    btn = b;
    cyc(12);
    @(negedge clock);
    btn = 4'b0000;
    cyc(12);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clock);
    rst_n = 1'b0;
    btn   = 4'b0000;
    cyc(2);
    @(negedge clock);
    rst_n = 1'b1;
  endtask

  initial begin
    int hits;
    tbl[0]  = '{4'b0001, 10'b1_0_001_1_1001};
    tbl[1]  = '{4'b0000, 10'b1_0_001_1_0001};
    tbl[2]  = '{4'b0010, 10'b1_0_001_1_1001};
    tbl[3]  = '{4'b0000, 10'b1_0_001_1_0001};
    tbl[4]  = '{4'b0001, 10'b0_0_001_1_1000};
    tbl[5]  = '{4'b0000, 10'b0_0_001_1_0000};
    tbl[6]  = '{4'b0010, 10'b0_1_001_1_1010};
    tbl[7]  = '{4'b0000, 10'b0_1_001_1_0010};
    tbl[8]  = '{4'b0100, 10'b0_1_010_1_1010};
    tbl[9]  = '{4'b0000, 10'b0_1_010_1_0010};
    tbl[10] = '{4'b1000, 10'b0_1_010_0_1110};
    tbl[11] = '{4'b0000, 10'b0_1_010_0_0110};
    tbl[12] = '{4'b0010, 10'b0_0_010_0_1100};
    tbl[13] = '{4'b0000, 10'b0_0_010_0_0100};
    tbl[14] = '{4'b0001, 10'b1_0_010_0_1101};
    tbl[15] = '{4'b0000, 10'b1_0_010_0_0101};
    tbl[16] = '{4'b1000, 10'b1_0_010_1_1001};
    tbl[17] = '{4'b0000, 10'b1_0_010_1_0001};
    tbl[18] = '{4'b0001, 10'b0_0_010_1_1000};
    tbl[19] = '{4'b0000, 10'b0_0_010_1_0000};
    tbl[20] = '{4'b0011, 10'b1_0_010_1_1001};
    tbl[21] = '{4'b0000, 10'b1_0_010_1_0001};
    tbl[22] = '{4'b1001, 10'b0_0_010_0_1100};
    tbl[23] = '{4'b0000, 10'b0_0_010_0_0100};
    tbl[24] = '{4'b1000, 10'b0_0_010_1_1000};
    tbl[25] = '{4'b0000, 10'b0_0_010_1_0000};

    // reset held with buttons toggling
    for (int i = 0; i < 12; i++) begin
      @(negedge clock);
      btn = 4'(i);
      @(posedge clock);
      #1;
      if (i % 3 == 0) begin
        chk("rst_hold", outs(), RST);
        chk("rst_hold_restart", o_restart, 1'b0);
      end
    end
    @(negedge clock);
    btn = 4'b0000;
    cyc(10);
    @(negedge clock);
    rst_n = 1'b1;
    cyc(3);
    #1;
    chk("rst_release", outs(), RST);

    // table of press/release vectors
    for (int i = 0; i < 26; i++) begin
      @(negedge clock);
      btn = tbl[i].btn;
      cyc(12);
      #1;
      chk($sformatf("vec%0d", i), outs(), tbl[i].exp);
    end

    // clean btn0 press latency and hold
    do_reset();
    @(negedge clock);
    btn = 4'b0001;
    for (int k = 0; k < 10; k++) begin
      @(posedge clock);
      #1;
      chk($sformatf("b0_mux_k%0d", k), o_mux_sel,
          32'(k >= 7));
      chk($sformatf("b0_rs_k%0d", k), o_restart,
          32'(k == 7));
    end
    hits = 0;
    for (int k = 0; k < 50; k++) begin
      @(posedge clock);
      #1;
      if (o_restart || !o_mux_sel) hits++;
    end
    chk("b0_hold_changes", hits, 0);

    // bouncing btn2
    do_reset();
    for (int c = 0; c < 20; c++) begin
      @(negedge clock);
      btn = ((c / 2) % 2 == 0) ? 4'b0100 : 4'b0000;
    end
    @(negedge clock);
    btn = 4'b0100;
    for (int k = 0; k < 10; k++) begin
      @(posedge clock);
      #1;
      chk($sformatf("bnc_col_k%0d", k), o_color,
          (k >= 7) ? 3'b010 : 3'b001);
    end
    @(negedge clock);
    btn = 4'b0000;
    cyc(12);
    press(4'b0100);
    chk("col_b", o_color, 3'b100);
    press(4'b0100);
    chk("col_r", o_color, 3'b001);
    press(4'b0100);
    chk("col_g", o_color, 3'b010);

    // reset mid-debounce while paused, btn3 held
    press(4'b1000);
    chk("pre_rst_run", o_run, 1'b0);
    @(negedge clock);
    btn = 4'b0001;
    cyc(3);
    #2;
    rst_n = 1'b0;
    btn   = 4'b1000;
    #1;
    chk("async_rst", outs(), RST);
    chk("async_rst_rs", o_restart, 1'b0);
    cyc(3);
    @(negedge clock);
    rst_n = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(posedge clock);
      #1;
      chk($sformatf("held_run_k%0d", k), o_run,
          32'(k < 7));
      chk($sformatf("held_rs_k%0d", k), o_restart, 0);
    end
    chk("held_final", outs(), 10'b0_0_001_0_1100);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/led_mode_ctrl.md
# led_mode_ctrl

Control block for the LED sequencer. It debounces the board push-buttons and runs the mode state machine. It also drives the configuration signals of the LED datapath: shift/flash mux select, shift direction, RGB colour select, run/pause gating of the tick counter, and a restart pulse. It sits between the raw `i_btn` pins and the counter, shift register, flash, mux and LED-colour blocks in the top level.

## Interface
- `N_BTN`, 4: number of buttons; bits 0..3 have fixed functions, extra bits are ignored.
- `N_ILEDS`, 4: width of the indicator LED output.
- `DB_CYCLES`, 1000000: consecutive stable cycles a synchronised button level needs before it is accepted (10 ms at 100 MHz); minimum 2.
- `DB_WIDTH`, 20: debounce counter width; must satisfy 2^DB_WIDTH > DB_CYCLES.
- `clock`, in, 1: system clock; all logic is on the rising edge.
- `i_ck_reset`, in, 1: reset, **asynchronous, active-low**.
- `i_btn`, in, N_BTN: raw asynchronous push-buttons, high = pressed.
- `o_mux_sel`, out, 1: 0 = shift register drives the LEDs, 1 = flash drives the LEDs.
- `o_shift_dir`, out, 1: 0 = shift right, 1 = shift left.
- `o_color`, out, 3: one-hot colour select; 001 = R, 010 = G, 100 = B.
- `o_run`, out, 1: counter enable; 0 freezes the sequence.
- `o_restart`, out, 1: one-cycle pulse that reloads the shift register and flash.
- `o_ind`, out, N_ILEDS: indicators; bit0 = flash mode, bit1 = shift left, bit2 = paused, bit3 = any debounced button held.

## Operation
- **Per-button front end:**
  - two-flop synchroniser, then a debounced level register `db` with its own `DB_WIDTH` counter;
  - the counter clears whenever the synchronised level equals `db`, otherwise it increments;
  - when the counter reaches DB_CYCLES-1 while the levels still differ, `db` takes the synchronised level and the counter clears;
  - a press event is the registered 0->1 transition of `db`, one cycle wide; releases generate no event.
- **State machine:** states SHIFT, FLASH, PAUSE. A `saved_mode` register (SHIFT/FLASH) holds the mode to resume after PAUSE.
- **btn0 (mode):**
  - SHIFT->FLASH and FLASH->SHIFT;
  - in PAUSE it toggles `saved_mode` and stays in PAUSE;
  - always pulses `o_restart`.
- **btn1 (direction):** toggles `o_shift_dir` only if the effective mode before the event is SHIFT and btn0 has no event in the same cycle. Otherwise it is ignored.
- **btn2 (colour):** rotates R->G->B->R in any state.
- **btn3 (pause):**
  - SHIFT or FLASH -> PAUSE, storing the current mode in `saved_mode`;
  - PAUSE -> `saved_mode`.
- **Simultaneous events:** all are evaluated against the pre-event state and applied in the same cycle. For btn0 and btn3 together from SHIFT, the result is PAUSE with `saved_mode` = FLASH and a restart pulse.
- **Output decode:**
  - `o_mux_sel` = 1 when the effective mode is FLASH (the current state, or `saved_mode` while in PAUSE);
  - `o_run` = 0 only in PAUSE;
  - outputs are registered, not combinational from the events.
- **Reset values:**
  - state SHIFT, `saved_mode` SHIFT;
  - `o_mux_sel` 0, `o_shift_dir` 0, `o_color` 001, `o_run` 1, `o_restart` 0, `o_ind` 0000;
  - synchronisers, `db` and counters all 0.

## Timing
- **Press latency:**
  - a raw level first sampled high at edge E gives `db` = 1 at edge E+DB_CYCLES+1;
  - the event register rises at E+DB_CYCLES+2;
  - state and outputs update at edge E+DB_CYCLES+3.
- **Glitch rejection:** a bounce shorter than DB_CYCLES synchronised cycles restarts the count and produces no event.
- **`o_restart`:** high for exactly one cycle, aligned with the `o_mux_sel` change (or with the `saved_mode` change in PAUSE).
- **Held button:** produces exactly one event; a new event requires a debounced release and then a debounced press.
- **Reset asserted mid-debounce or mid-pulse:** everything returns to reset values immediately; no pulse completes.
- **Button held across reset release:** because `db` restarts at 0, a held button gives one event DB_CYCLES+3 cycles after the first edge following deassertion.
- **bit3 of `o_ind`:** follows the OR of the `db` levels with one cycle of register delay.

## Test plan
- **Reset (DB_CYCLES=4):** hold `i_ck_reset`=0 and toggle the buttons -> outputs stay at reset values; release reset -> `o_color`=001, `o_run`=1, `o_mux_sel`=0.
- **Clean btn0 press** raised before edge E -> `o_mux_sel` goes 1 and `o_restart` is high for one cycle at E+7; hold for 50 cycles -> no further change.
- **Bounce:** btn2 toggling every 2 cycles for 20 cycles, then stable high -> exactly one colour step, 001->010, seven cycles after the last edge; three more presses -> 100, 001, 010.
- **Direction:** btn1 in SHIFT -> `o_shift_dir`=1. btn1 in FLASH -> unchanged. btn0 and btn1 on the same cycle from SHIFT -> FLASH, dir unchanged.
- **Pause:** btn3 in FLASH -> `o_run`=0, `o_ind`=0101. btn0 while paused -> `o_mux_sel`=0, restart pulse, `o_run` still 0. btn3 -> SHIFT, `o_run`=1.
- **Reset mid-operation:** reset during a debounce count and while in PAUSE -> immediate reset values; btn3 held through the release -> one PAUSE entry seven cycles after the first post-release edge.
